// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer: byte-enable codes, FIFO entry record
// and drain FSM state encoding.
package store_write_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// In-order store FIFO with per-entry valid bits and a parallel word-address
// compare used for load hazard detection.
module store_buffer_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head_entry,
    output sb_entry_t        next_entry,
    output logic [PTR_W:0]   count,
    input  logic [29:0]      cmp_addr,
    output logic             cmp_hit
);

    sb_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid_reg;
    logic [DEPTH-1:0]   hit_vec;
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [PTR_W-1:0]   head_next;
    logic [PTR_W:0]     count_reg;

    assign head_next = head_reg + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Push never targets the head slot while it is being popped: a push
            // only happens when not full, and a pop only when non-empty.
            if (push) begin
                tail_reg           <= tail_reg + PTR_W'(1);
                valid_reg[tail_reg] <= 1'b1;
            end
            if (pop) begin
                head_reg           <= head_next;
                valid_reg[head_reg] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_reg] <= push_entry;
        end
    end

    assign head_entry = entries[head_reg];
    assign next_entry = entries[head_next];
    assign count      = count_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign hit_vec[gi] = valid_reg[gi] && (entries[gi].addr == cmp_addr);
    end

    assign cmp_hit = |hit_vec;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer: queues stores, drains them in order to memory over a
// req/ack handshake, and flags loads that hit a pending store word.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_byteen,
    input  logic [31:0] st_wdata,
    output logic        st_stall,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byteen,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        sb_empty
);

    logic [PTR_W:0] count;
    logic           push;
    logic           pop;
    logic           cmp_hit;
    sb_entry_t      st_entry;
    sb_entry_t      head_entry;
    sb_entry_t      next_entry;
    drain_state_t   state_reg;
    logic           mem_req_reg;
    logic [31:0]    mem_addr_reg;
    logic [3:0]     mem_byteen_reg;
    logic [31:0]    mem_wdata_reg;
    logic           unused_low_bits;

    assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_entry = '{addr: st_addr[31:2], byteen: st_byteen, wdata: st_wdata};
    assign st_stall = (count == (PTR_W+1)'(DEPTH));
    assign push     = st_valid && !st_stall && (st_byteen != BE_NONE);
    assign pop      = (state_reg == S_BUSY) && mem_ack;

    store_buffer_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (st_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .count      (count),
        .cmp_addr   (ld_addr[31:2]),
        .cmp_hit    (cmp_hit)
    );

    // When the buffer is empty, a store being pushed is forwarded straight into
    // the mem_* registers so it reaches the port one cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            mem_byteen_reg <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (count != '0) begin
                        state_reg      <= S_BUSY;
                        mem_req_reg    <= 1'b1;
                        mem_addr_reg   <= {head_entry.addr, 2'b00};
                        mem_byteen_reg <= head_entry.byteen;
                        mem_wdata_reg  <= head_entry.wdata;
                    end else if (push) begin
                        state_reg      <= S_BUSY;
                        mem_req_reg    <= 1'b1;
                        mem_addr_reg   <= {st_entry.addr, 2'b00};
                        mem_byteen_reg <= st_entry.byteen;
                        mem_wdata_reg  <= st_entry.wdata;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        if (count > (PTR_W+1)'(1)) begin
                            mem_addr_reg   <= {next_entry.addr, 2'b00};
                            mem_byteen_reg <= next_entry.byteen;
                            mem_wdata_reg  <= next_entry.wdata;
                        end else if (push) begin
                            mem_addr_reg   <= {st_entry.addr, 2'b00};
                            mem_byteen_reg <= st_entry.byteen;
                            mem_wdata_reg  <= st_entry.wdata;
                        end else begin
                            state_reg      <= S_IDLE;
                            mem_req_reg    <= 1'b0;
                            mem_addr_reg   <= '0;
                            mem_byteen_reg <= '0;
                            mem_wdata_reg  <= '0;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_byteen = mem_byteen_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign ld_stall   = ld_valid && cmp_hit;
    assign sb_empty   = (count == '0) && !mem_req_reg;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random
// traffic checked against a queue-based model of pending stores.
module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [3:0]  st_byteen = '0;
    logic [31:0] st_wdata = '0;
    logic        st_stall;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        sb_empty;

    always #5 clk = ~clk;

    store_write_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteen  (st_byteen),
        .st_wdata   (st_wdata),
        .st_stall   (st_stall),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_stall   (ld_stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_byteen (mem_byteen),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .sb_empty   (sb_empty)
    );

    // Model: every accepted, not-yet-acknowledged store, oldest first.
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } store_t;
    store_t model_q[$];

    int errors = 0;
    int checks = 0;
    localparam int MODEL_DEPTH = 4;

    // Advance one clock, applying the model's accept/retire rules to the
    // inputs that were present just before the edge.
    task automatic tick();
        bit accept;
        bit retire;
        store_t s;
        accept = st_valid && (model_q.size() < MODEL_DEPTH) && (st_byteen != 4'b0000);
        retire = mem_ack && (model_q.size() != 0);
        s.addr = st_addr;
        s.be   = st_byteen;
        s.data = st_wdata;
        @(posedge clk);
        #1;
        if (retire) begin
            $display("write retired: addr=%h be=%b data=%h", model_q[0].addr & 32'hFFFF_FFFC,
                     model_q[0].be, model_q[0].data);
            void'(model_q.pop_front());
        end
        if (accept) model_q.push_back(s);
    endtask

    function automatic logic exp_ld_stall();
        logic hit;
        hit = 1'b0;
        foreach (model_q[i]) if (model_q[i].addr[31:2] == ld_addr[31:2]) hit = 1'b1;
        return ld_valid && hit;
    endfunction

    function automatic logic [68:0] exp_mem();
        if (model_q.size() == 0) return '0;
        return {1'b1, model_q[0].addr & 32'hFFFF_FFFC, model_q[0].be, model_q[0].data};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++;
        if ({mem_addr, mem_byteen, mem_wdata} !== 68'h0) begin
            errors++; $display("FAIL reset_mem_regs: got %h/%b/%h want 0", mem_addr, mem_byteen, mem_wdata);
        end
        checks++;
        if ({sb_empty, st_stall, ld_stall} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got empty/st/ld=%b want 100", {sb_empty, st_stall, ld_stall});
        end
        reset = 1'b0;
        model_q.delete();
        $display("reset released");
    endtask

    task automatic test_single_word();
        st_valid = 1'b1; st_addr = 32'h0000_1004; st_byteen = BE_WORD; st_wdata = 32'hDEAD_BEEF;
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL sw_latency: mem_req=%b want 1", mem_req); end
        checks++;
        if ({mem_addr, mem_byteen, mem_wdata} !== {32'h0000_1004, 4'b1111, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL sw_fields: got %h/%b/%h want 00001004/1111/deadbeef", mem_addr, mem_byteen, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({sb_empty, mem_req} !== 2'b10) begin
            errors++; $display("FAIL sw_after_ack: empty/req=%b want 10", {sb_empty, mem_req});
        end
    endtask

    task automatic test_byte_store();
        st_valid = 1'b1; st_addr = 32'h0000_2003; st_byteen = BE_B3; st_wdata = 32'h5A00_0000;
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_addr, mem_byteen} !== {32'h0000_2000, 4'b1000}) begin
            errors++; $display("FAIL sb_fields: got %h/%b want 00002000/1000", mem_addr, mem_byteen);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [31:0] sent [5];
        for (int i = 0; i < 5; i++) begin
            sent[i]   = {16'hA5A5, 16'(i)};
            st_valid  = 1'b1;
            st_addr   = 32'h0000_4000 + 32'(4 * i);
            st_byteen = BE_WORD;
            st_wdata  = sent[i];
            #1;
            checks++;
            if (st_stall !== (i == 4)) begin
                errors++; $display("FAIL full_stall_%0d: st_stall=%b want %b", i, st_stall, (i == 4));
            end
            tick();
        end
        #1;
        checks++;
        if (st_stall !== 1'b1) begin errors++; $display("FAIL full_held: st_stall=%b want 1", st_stall); end
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({mem_req, mem_wdata} !== {1'b1, sent[k]}) begin
                errors++; $display("FAIL drain_order_%0d: req/data=%b/%h want 1/%h", k, mem_req, mem_wdata, sent[k]);
            end
            tick();
            if (model_q.size() != 0 && model_q[$].data == sent[4]) st_valid = 1'b0;
        end
        mem_ack = 1'b0;
        st_valid = 1'b0;
        #1;
        checks++;
        if (sb_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: sb_empty=%b want 1", sb_empty); end
    endtask

    task automatic test_load_hazard();
        st_valid = 1'b1; st_addr = 32'h0000_3000; st_byteen = BE_WORD; st_wdata = 32'h1234_5678;
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h0000_3002;
        #1;
        checks++;
        if (ld_stall !== 1'b1) begin errors++; $display("FAIL ld_same_word: ld_stall=%b want 1", ld_stall); end
        ld_addr = 32'h0000_3004;
        #1;
        checks++;
        if (ld_stall !== 1'b0) begin errors++; $display("FAIL ld_other_word: ld_stall=%b want 0", ld_stall); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ld_addr = 32'h0000_3002;
        #1;
        checks++;
        if (ld_stall !== 1'b0) begin errors++; $display("FAIL ld_after_ack: ld_stall=%b want 0", ld_stall); end
        ld_valid = 1'b0;
    endtask

    task automatic test_zero_byteen();
        st_valid = 1'b1; st_addr = 32'h0000_5000; st_byteen = BE_NONE; st_wdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (st_stall !== 1'b0) begin errors++; $display("FAIL be0_stall: st_stall=%b want 0", st_stall); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({mem_req, sb_empty} !== 2'b01) begin
            errors++; $display("FAIL be0_dropped: req/empty=%b want 01", {mem_req, sb_empty});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h0000_6000 + 32'(4 * i); st_byteen = BE_HLO; st_wdata = $urandom;
            tick();
        end
        st_valid = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_busy: mem_req=%b want 1", mem_req); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, sb_empty} !== 2'b01) begin
            errors++; $display("FAIL mid_reset_async: req/empty=%b want 01", {mem_req, sb_empty});
        end
        checks++;
        if ({mem_addr, mem_byteen, mem_wdata} !== 68'h0) begin
            errors++; $display("FAIL mid_reset_regs: got %h/%b/%h want 0", mem_addr, mem_byteen, mem_wdata);
        end
        model_q.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        $display("reset pulsed mid-operation");
        @(posedge clk);
        #1;
        checks++;
        if ({mem_req, sb_empty} !== 2'b01) begin
            errors++; $display("FAIL mid_reset_after: req/empty=%b want 01", {mem_req, sb_empty});
        end
    endtask

    task automatic test_random();
        logic [3:0] be_codes [8];
        be_codes = '{BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_HLO, BE_HHI, BE_WORD};
        for (int c = 0; c < 400; c++) begin
            st_valid  = ($urandom_range(0, 99) < 60);
            st_addr   = 32'h0000_7000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            st_byteen = be_codes[$urandom_range(0, 7)];
            st_wdata  = $urandom;
            ld_valid  = $urandom_range(0, 1);
            ld_addr   = 32'h0000_7000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            mem_ack   = (c >= 380) ? 1'b1 : ($urandom_range(0, 99) < 45);
            #1;
            checks++;
            if (st_stall !== (model_q.size() == MODEL_DEPTH)) begin
                errors++; $display("FAIL rnd_st_stall c=%0d: got %b want %b", c, st_stall, (model_q.size() == MODEL_DEPTH));
            end
            checks++;
            if (ld_stall !== exp_ld_stall()) begin
                errors++; $display("FAIL rnd_ld_stall c=%0d: got %b want %b", c, ld_stall, exp_ld_stall());
            end
            checks++;
            if ({mem_req, mem_addr, mem_byteen, mem_wdata} !== exp_mem()) begin
                errors++; $display("FAIL rnd_mem c=%0d: got %h want %h", c,
                                   {mem_req, mem_addr, mem_byteen, mem_wdata}, exp_mem());
            end
            checks++;
            if (sb_empty !== (model_q.size() == 0)) begin
                errors++; $display("FAIL rnd_sb_empty c=%0d: got %b want %b", c, sb_empty, (model_q.size() == 0));
            end
            if (c >= 380) st_valid = 1'b0;
            tick();
        end
        st_valid = 1'b0; ld_valid = 1'b0; mem_ack = 1'b0;
        #1;
        checks++;
        if ({sb_empty, mem_req} !== 2'b10) begin
            errors++; $display("FAIL rnd_final_empty: empty/req=%b want 10", {sb_empty, mem_req});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_byte_store();
        test_full_stall();
        test_load_hazard();
        test_zero_byteen();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
